// File: rtl/ldpc_check_node_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_check_node_scheduler
// Brief    : Row/iteration sequencer for the 7-input min-sum check-node unit,
//            with row-tag FIFO for write-back and an iteration barrier.
// Revision : 1.0 - initial release
// ============================================================================
module ldpc_check_node_scheduler #(
  parameter int ROW_W      = 8,
  parameter int ITER_W     = 5,
  parameter int MEM_LAT    = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ROW_W-1:0]  i_num_rows,
  input  logic [ITER_W-1:0] i_num_iters,
  input  logic              i_stall,
  input  logic              i_ms_valid,
  output logic              o_rd_en,
  output logic [ROW_W-1:0]  o_rd_addr,
  output logic              o_ms_valid,
  output logic              o_wr_en,
  output logic [ROW_W-1:0]  o_wr_addr,
  output logic [ITER_W-1:0] o_iter,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ROW_W-1:0]    r_row;
  logic [ROW_W-1:0]    r_num_rows;
  logic [ITER_W-1:0]   r_iter;
  logic [ITER_W-1:0]   r_num_iters;
  logic [c_cnt_w-1:0]  r_outstanding;
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [ROW_W-1:0]    r_tag_mem [FIFO_DEPTH];
  logic [MEM_LAT-1:0]  r_ms_pipe;
  logic                r_err;

  logic w_rd_en;
  logic w_wr_en;
  logic w_done;
  logic w_busy;
  logic w_start_ok;
  logic w_not_full;
  logic w_last_row;
  logic w_last_iter;
  logic w_drained;
  logic w_spurious;

  assign w_start_ok  = i_start && (i_num_rows != '0) && (i_num_iters != '0);
  assign w_not_full  = (r_outstanding < c_depth);
  assign w_last_row  = (r_row == r_num_rows - 1'b1);
  assign w_last_iter = (r_iter == r_num_iters - 1'b1);
  assign w_drained   = (r_outstanding == '0);
  assign w_wr_en     = i_ms_valid && !w_drained;
  assign w_spurious  = i_ms_valid && w_drained;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_done       = 1'b0;
    w_busy       = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_start_ok) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_rd_en = !i_stall && w_not_full;
        if (w_rd_en && w_last_row) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drained) begin
          w_state_next = w_last_iter ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Row/iteration counters and the sticky error; a spurious valid wins over a start clear.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_row       <= '0;
      r_iter      <= '0;
      r_num_rows  <= '0;
      r_num_iters <= '0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_start_ok) begin
        r_num_rows  <= i_num_rows;
        r_num_iters <= i_num_iters;
        r_row       <= '0;
        r_iter      <= '0;
        r_err       <= 1'b0;
      end
      if (w_rd_en) begin
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end
      if (r_state == S_DRAIN && w_drained && !w_last_iter) begin
        r_iter <= r_iter + 1'b1;
        r_row  <= '0;
      end
      if (w_spurious) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_rd_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_wr_en) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_rd_en, w_wr_en})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_rd_en) begin
      r_tag_mem[r_wr_ptr] <= r_row;
    end
  end

  // Memory-latency delay of the read strobe; never gated so in-flight strobes complete.
  generate
    if (MEM_LAT == 1) begin : g_lat_one
      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          r_ms_pipe <= '0;
        end else begin
          r_ms_pipe <= w_rd_en;
        end
      end
    end else begin : g_lat_multi
      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          r_ms_pipe <= '0;
        end else begin
          r_ms_pipe <= {r_ms_pipe[MEM_LAT-2:0], w_rd_en};
        end
      end
    end
  endgenerate

  assign o_rd_en    = w_rd_en;
  assign o_rd_addr  = r_row;
  assign o_ms_valid = r_ms_pipe[MEM_LAT-1];
  assign o_wr_en    = w_wr_en;
  // Head is only meaningful with rows in flight; hold the address at zero otherwise.
  assign o_wr_addr  = w_drained ? '0 : r_tag_mem[r_rd_ptr];
  assign o_iter     = r_iter;
  assign o_busy     = w_busy;
  assign o_done     = w_done;
  assign o_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_check_node_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldpc_check_node_scheduler
// Brief    : Directed self-checking bench with a fixed-latency minsigner model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldpc_check_node_scheduler;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic [7:0] i_num_rows;
  logic [4:0] i_num_iters;
  logic       i_stall = 1'b0;
  logic       i_ms_valid = 1'b0;
  logic       o_rd_en;
  logic [7:0] o_rd_addr;
  logic       o_ms_valid;
  logic       o_wr_en;
  logic [7:0] o_wr_addr;
  logic [4:0] o_iter;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  ldpc_check_node_scheduler #(
    .ROW_W(8), .ITER_W(5), .MEM_LAT(1), .FIFO_DEPTH(8)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
    .i_num_rows(i_num_rows), .i_num_iters(i_num_iters), .i_stall(i_stall),
    .i_ms_valid(i_ms_valid), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .o_ms_valid(o_ms_valid), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_iter(o_iter), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clock = ~i_clock;

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  logic [31:0] w_outs;
  assign w_outs = {5'd0, o_rd_en, o_rd_addr, o_ms_valid, o_wr_en, o_wr_addr,
                   o_iter, o_busy, o_done, o_err};

  // Minsigner model: i_ms_valid follows o_ms_valid by lat cycles.
  logic [31:0] hist = '0;
  int  lat = 2;
  bit  model_en = 1'b1;
  bit  inject = 1'b0;
  bit  stall_mode = 1'b0;
  always @(negedge i_clock) begin
    i_ms_valid = model_en ? hist[lat-1] : inject;
    hist       = {hist[30:0], o_ms_valid};
    i_stall    = stall_mode ? cyc[0] : 1'b0;
  end

  int rd_a[$], rd_t[$], rd_it[$], msv_t[$], wr_a[$], wr_t[$], done_t[$], fall_t[$];
  int stall_viol = 0, stall_seen = 0, busy_cnt = 0, nz_cnt = 0;
  bit busy_prev = 1'b0;
  always @(negedge i_clock) begin
    #1;
    if (o_rd_en) begin
      rd_a.push_back(int'(o_rd_addr));
      rd_t.push_back(cyc);
      rd_it.push_back(int'(o_iter));
      if (i_stall) stall_viol++;
    end
    if (i_stall) stall_seen++;
    if (o_ms_valid) msv_t.push_back(cyc);
    if (o_wr_en) begin
      wr_a.push_back(int'(o_wr_addr));
      wr_t.push_back(cyc);
    end
    if (o_done) done_t.push_back(cyc);
    if (o_busy) busy_cnt++;
    if (busy_prev && !o_busy) fall_t.push_back(cyc);
    busy_prev = o_busy;
    if (w_outs != 32'd0) nz_cnt++;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_value(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1000;
  endfunction

  task automatic tick();
    @(posedge i_clock);
    #2;
  endtask

  task automatic start_run(input int rows, input int iters, output int t);
    i_num_rows  = 8'(rows);
    i_num_iters = 5'(iters);
    i_start     = 1'b1;
    @(posedge i_clock);
    #2;
    t       = cyc;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int b0;
    int n;
    b0 = done_t.size();
    n  = 0;
    while (done_t.size() == b0 && n < budget) begin
      tick();
      n++;
    end
    check_value(tag, int'(done_t.size() > b0), 1);
    repeat (3) tick();
  endtask

  int t0, br, bm, bw, bd, bf, bv, bs, bb, bn;

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_num_rows = '0; i_num_iters = '0;
    repeat (3) tick();
    check_value("reset_outs", int'(w_outs), 0);
    check_value("reset_busy", int'(o_busy), 0);
    i_reset = 1'b0;
    tick();

    // 1: null start
    bb = busy_cnt; bn = nz_cnt;
    start_run(0, 3, t0);
    repeat (10) tick();
    check_value("null_busy", busy_cnt - bb, 0);
    check_value("null_outs", nz_cnt - bn, 0);

    // 2: single iteration, 4 rows
    br = rd_t.size(); bm = msv_t.size(); bw = wr_t.size();
    bd = done_t.size(); bf = fall_t.size();
    start_run(4, 1, t0);
    wait_done("t2_done_seen", 40);
    check_value("t2_rd_cnt", rd_t.size() - br, 4);
    check_value("t2_wr_cnt", wr_t.size() - bw, 4);
    for (int i = 0; i < 4; i++) begin
      check_value($sformatf("t2_rd_addr%0d", i), q_at(rd_a, br + i), i);
      check_value($sformatf("t2_rd_cyc%0d", i), q_at(rd_t, br + i) - t0 + 1, 1 + i);
      check_value($sformatf("t2_msv_cyc%0d", i), q_at(msv_t, bm + i) - t0 + 1, 2 + i);
      check_value($sformatf("t2_wr_addr%0d", i), q_at(wr_a, bw + i), i);
      check_value($sformatf("t2_wr_cyc%0d", i), q_at(wr_t, bw + i) - t0 + 1, 4 + i);
    end
    check_value("t2_done_cyc", q_at(done_t, bd) - t0 + 1, 9);
    check_value("t2_busy_fall", q_at(fall_t, bf) - t0 + 1, 10);

    // 3: iteration barrier
    br = rd_t.size(); bw = wr_t.size();
    start_run(2, 3, t0);
    wait_done("t3_done_seen", 100);
    check_value("t3_wr_cnt", wr_t.size() - bw, 6);
    for (int i = 0; i < 6; i++) begin
      check_value($sformatf("t3_wr_addr%0d", i), q_at(wr_a, bw + i), i % 2);
      check_value($sformatf("t3_rd_iter%0d", i), q_at(rd_it, br + i), i / 2);
    end
    check_value("t3_barrier1", q_at(rd_t, br + 2) - q_at(wr_t, bw + 1), 2);
    check_value("t3_barrier2", q_at(rd_t, br + 4) - q_at(wr_t, bw + 3), 2);
    check_value("t3_final_iter", int'(o_iter), 2);
    check_value("t3_err", int'(o_err), 0);

    // 4: backpressure with a slow minsigner
    repeat (25) tick();
    lat = 20;
    br = rd_t.size(); bw = wr_t.size();
    start_run(12, 1, t0);
    wait_done("t4_done_seen", 200);
    check_value("t4_rd_cnt", rd_t.size() - br, 12);
    check_value("t4_rd7_cyc", q_at(rd_t, br + 7) - t0 + 1, 8);
    check_value("t4_rd8_cyc", q_at(rd_t, br + 8) - t0 + 1, 23);
    for (int k = 0; k < 4; k++)
      check_value($sformatf("t4_resume%0d", k), q_at(rd_t, br + 8 + k) - q_at(wr_t, bw + k), 1);
    check_value("t4_wr_cnt", wr_t.size() - bw, 12);
    for (int i = 0; i < 12; i++)
      check_value($sformatf("t4_wr_addr%0d", i), q_at(wr_a, bw + i), i);
    check_value("t4_err", int'(o_err), 0);
    repeat (5) tick();
    lat = 2;
    repeat (3) tick();

    // 5: alternate-cycle stall
    br = rd_t.size(); bv = stall_viol; bs = stall_seen;
    stall_mode = 1'b1;
    start_run(6, 1, t0);
    wait_done("t5_done_seen", 100);
    stall_mode = 1'b0;
    check_value("t5_stall_rd", stall_viol - bv, 0);
    check_value("t5_stall_seen", int'(stall_seen - bs > 0), 1);
    check_value("t5_rd_cnt", rd_t.size() - br, 6);
    for (int i = 0; i < 6; i++)
      check_value($sformatf("t5_rd_addr%0d", i), q_at(rd_a, br + i), i);

    // 6: spurious valid, reset mid-issue, recovery
    model_en = 1'b0;
    tick();
    inject = 1'b1;
    @(negedge i_clock);
    #2;
    check_value("t6_spur_wr", int'(o_wr_en), 0);
    tick();
    check_value("t6_spur_err", int'(o_err), 1);
    inject = 1'b0;
    tick();
    model_en = 1'b1;
    repeat (3) tick();
    start_run(6, 1, t0);
    repeat (2) tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    check_value("t6_rst_outs", int'(w_outs), 0);
    repeat (6) tick();
    check_value("t6_late_err", int'(o_err), 1);
    bw = wr_t.size();
    start_run(3, 1, t0);
    tick();
    check_value("t6_err_clr", int'(o_err), 0);
    wait_done("t6_done_seen", 60);
    check_value("t6_wr_cnt", wr_t.size() - bw, 3);
    for (int i = 0; i < 3; i++)
      check_value($sformatf("t6_wr_addr%0d", i), q_at(wr_a, bw + i), i);
    check_value("t6_err_final", int'(o_err), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/ldpc_check_node_scheduler.md
# ldpc_check_node_scheduler

Sequencer for the 7-input LDPC min-sum check-node unit (`ldpc_minsigner`). It iterates over the check rows of the parity-check matrix for a configured number of decoding iterations. For each row it issues edge-memory reads, drives the minsigner valid strobe, and tags each minsigner result with its row so the result is written back to the right address. An iteration barrier ensures that row reads for iteration k+1 start only after every write of iteration k has landed.

## Interface
Parameters:
- ROW_W, 8, width of the row index and memory address.
- ITER_W, 5, width of the iteration count.
- MEM_LAT, 1, edge-memory read latency in cycles (≥1).
- FIFO_DEPTH, 8, maximum number of rows in flight (power of two). It must exceed MEM_LAT plus the minsigner latency to allow full throughput.

Ports:
- i_clock  in  1  clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_start  in  1  starts a decode. Sampled only in IDLE.
- i_num_rows  in  ROW_W  number of rows per iteration (rows 0..N-1). Latched on start.
- i_num_iters  in  ITER_W  number of iterations. Latched on start.
- i_stall  in  1  when high, no new row read is issued.
- i_ms_valid  in  1  minsigner `o_valid`.
- o_rd_en  out  1  edge-memory read strobe.
- o_rd_addr  out  ROW_W  row being read.
- o_ms_valid  out  1  minsigner `i_valid`. Equals o_rd_en delayed by MEM_LAT cycles.
- o_wr_en  out  1  write-back strobe.
- o_wr_addr  out  ROW_W  write-back row, taken from the FIFO head.
- o_iter  out  ITER_W  current iteration index.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  sticky flag: i_ms_valid arrived with nothing in flight.

## Operation
- **State machine:** IDLE → ISSUE → DRAIN → (ISSUE | DONE) → IDLE.
- **IDLE:**
  - On i_start with i_num_rows≠0 and i_num_iters≠0: latch the configuration, set row=0 and iter=0, clear o_err, go to ISSUE.
  - A start with a zero row count or zero iteration count is ignored.
- **ISSUE:**
  - o_rd_en = !i_stall && (outstanding < FIFO_DEPTH). This is combinational from registered state.
  - o_rd_addr = row.
  - Each issue pushes row into the tag FIFO and increments row.
  - Issuing row num_rows-1 moves to DRAIN.
- **DRAIN:**
  - No reads are issued.
  - Once outstanding==0: if iter==num_iters-1, go to DONE; otherwise increment iter, set row=0, go to ISSUE.
- **DONE:** o_done=1 for one cycle, then IDLE.
- **Write-back:**
  - o_wr_en = i_ms_valid && outstanding≠0, combinational, so minsigner output data and o_wr_addr align in the same cycle.
  - A write pops the FIFO.
- **Outstanding counter:**
  - A push and a pop in the same cycle leave the count unchanged.
  - The count never exceeds FIFO_DEPTH and never goes below 0.
- **Spurious valid:** i_ms_valid with outstanding==0, in any state, sets o_err. The write and the pop are suppressed.
- **Ignored input:** i_start while busy is ignored.
- **o_ms_valid shift register:**
  - Cleared by reset.
  - Not gated by i_stall; in-flight strobes always complete.

## Timing
- **Reset values:** all outputs 0. The state machine, counters, FIFO pointers and valid shift register all clear.
- **Reset mid-operation:** outputs read 0 in the cycle after reset is sampled. In-flight results are discarded; any i_ms_valid that arrives later sets o_err.
- **Start latency:** with start sampled at edge T:
  - the first o_rd_en is in cycle T+1;
  - the first o_ms_valid is in cycle T+1+MEM_LAT.
- **Throughput:** one row per cycle when not stalled and the FIFO is not full.
- **Barrier penalty:** a DRAIN that finds outstanding==0 leaves in the next cycle, so the first read of the next iteration occurs 2 cycles after the last write of the previous iteration.
- **Completion:** o_done is asserted in the cycle after DRAIN sees outstanding==0 on the last iteration. o_busy falls in the following cycle.

## Test plan
Bench model of the minsigner: fixed latency L=2, MEM_LAT=1.

1. **Reset and null start.** Hold reset; then start with num_rows=0, num_iters=3 → every output stays 0 and o_busy never rises.
2. **Single iteration.** num_rows=4, num_iters=1, start at edge T →
   - o_rd_addr 0,1,2,3 in cycles T+1..T+4;
   - o_ms_valid in T+2..T+5;
   - o_wr_addr 0..3 in T+4..T+7;
   - o_done in T+9, o_busy low from T+10.
3. **Iteration barrier.** num_rows=2, num_iters=3 →
   - 6 writes, rows 0,1,0,1,0,1;
   - o_iter steps 0→1→2;
   - each row-0 read falls exactly 2 cycles after the prior iteration's last write.
4. **Backpressure.** Bench latency 20, num_rows=12 →
   - o_rd_en stops after 8 reads;
   - reads then resume one per write;
   - all 12 addresses are written, in order.
5. **Stall.** num_rows=6, i_stall high on alternate cycles → no o_rd_en while stall is high; read addresses 0..5 with no gaps or duplicates.
6. **Error and reset recovery.**
   - Inject i_ms_valid in IDLE → o_err=1, o_wr_en=0.
   - Assert reset mid-ISSUE → all outputs 0 next cycle; a later start runs cleanly with o_err cleared.
